// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the pc_sequencer instruction-cycle
// controller: sequencer states, opcode encodings and instruction field
// positions, plus the conditional-jump resolution helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4,
        HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Opcode field; the jump target occupies the low ADDR_W bits of ir.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    // Whether a jump-class opcode takes the load path for the given zero flag.
    function automatic logic cond_taken(input logic [3:0] op, input logic z);
        case (op)
            OP_JMP:  cond_taken = 1'b1;
            OP_JZ:   cond_taken = z;
            OP_JNZ:  cond_taken = ~z;
            default: cond_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack -- small LIFO of return addresses for CALL/RET.
// Ports:
//   clk, rst        clock / synchronous active-high reset (clears the pointer)
//   push, pop       operations; ignored when full / empty respectively
//   push_data [W]   address to push
//   top [W]         current top entry (0 when empty)
//   full, empty     occupancy flags
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] sp;
    logic [W-1:0]  mem [DEPTH];

    assign full  = (sp == PW'(DEPTH));
    assign empty = (sp == '0);
    assign top   = empty ? '0 : mem[IW'(sp - PW'(1))];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    // Storage itself is not reset; only the pointer decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- instruction-cycle controller for the program_counter.
// Runs FETCH / DECODE / EXEC / UPDATE, handles the instruction-memory read
// handshake and resolves JMP / JZ / JNZ / HALT.
// Optional feature macro: PC_SEQ_CALL_STACK_EN adds CALL/RET with a
// STACK_DEPTH-entry return stack and a sticky fault flag.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   run                      keep sequencing; 0 stops at next instruction boundary
//   pc_value [ADDR_W]        current program_counter value
//   mem_rd_req / mem_rd_ack  instruction read handshake, mem_rd_data [INSTR_W]
//   exec_start / exec_done   execute datapath handshake, flag_z zero flag
//   pc_load, pc_inc, pc_enOut, pc_in_value [ADDR_W]  program_counter controls
//   ir [INSTR_W]             latched instruction
//   halted                   in HALTED state
//   fault                    sticky stack error (0 without the feature)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_value,
    output logic               mem_rd_req,
    input  logic               mem_rd_ack,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic               flag_z,
    output logic               pc_load,
    output logic               pc_inc,
    output logic               pc_enOut,
    output logic [ADDR_W-1:0]  pc_in_value,
    output logic [INSTR_W-1:0] ir,
    output logic               halted,
    output logic               fault
);

    state_t state, state_nx;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic              upd_load;    // UPDATE takes the load path
    logic              exec_first;  // first EXEC cycle: pulse start, ignore done
    logic              dec_load;
    logic [ADDR_W-1:0] dec_value;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign target = ir[ADDR_W-1:0];

`ifdef PC_SEQ_CALL_STACK_EN
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic              dec_fault;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_value + ADDR_W'(1)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (dec_fault) begin
            fault <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{pc_value, (STACK_DEPTH > 0)};
    assign fault      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and decode resolution
    always_comb begin
        state_nx  = state;
        dec_load  = 1'b0;
        dec_value = target;
`ifdef PC_SEQ_CALL_STACK_EN
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        dec_fault = 1'b0;
`endif
        case (state)
            IDLE:   if (run) state_nx = FETCH;
            FETCH:  if (mem_rd_ack) state_nx = DECODE;
            DECODE: begin
                case (opcode)
                    OP_HALT: state_nx = HALTED;
                    OP_JMP, OP_JZ, OP_JNZ: begin
                        dec_load = cond_taken(opcode, flag_z);
                        state_nx = UPDATE;
                    end
`ifdef PC_SEQ_CALL_STACK_EN
                    OP_CALL: begin
                        if (stk_full) begin
                            dec_fault = 1'b1;
                            state_nx  = HALTED;
                        end else begin
                            stk_push = 1'b1;
                            dec_load = 1'b1;
                            state_nx = UPDATE;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            dec_fault = 1'b1;
                            state_nx  = HALTED;
                        end else begin
                            stk_pop   = 1'b1;
                            dec_load  = 1'b1;
                            dec_value = stk_top;
                            state_nx  = UPDATE;
                        end
                    end
`endif
                    default: state_nx = EXEC;
                endcase
            end
            EXEC:   if (!exec_first && exec_done) state_nx = UPDATE;
            UPDATE: state_nx = run ? FETCH : IDLE;
            HALTED: state_nx = HALTED;
            default: state_nx = IDLE;
        endcase
    end

    // Instruction register and decode results carried into EXEC / UPDATE
    always_ff @(posedge clk) begin
        if (rst) begin
            ir          <= '0;
            pc_in_value <= '0;
            upd_load    <= 1'b0;
            exec_first  <= 1'b0;
        end else begin
            if (state == FETCH && mem_rd_ack) begin
                ir <= mem_rd_data;
            end
            if (state == DECODE) begin
                upd_load   <= dec_load;
                exec_first <= (state_nx == EXEC);
                if (dec_load) begin
                    pc_in_value <= dec_value;
                end
            end else if (state == EXEC) begin
                exec_first <= 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        mem_rd_req = 1'b0;
        pc_enOut   = 1'b0;
        exec_start = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                mem_rd_req = 1'b1;
                pc_enOut   = 1'b1;
            end
            EXEC:   exec_start = exec_first;
            UPDATE: begin
                pc_load = upd_load;
                pc_inc  = ~upd_load;
            end
            HALTED: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: program_counter stand-in, instruction memory
// and execute responders, an instruction-level reference model checked every
// cycle, and directed tests with literal expectations.
module tb_pc_sequencer;

    localparam int STACK_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [8:0]  pc_value;
    logic        mem_rd_req;
    logic        mem_rd_ack = 1'b0;
    logic [15:0] mem_rd_data = 16'h0;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic        flag_z = 1'b0;
    logic        pc_load, pc_inc, pc_enOut;
    logic [8:0]  pc_in_value;
    logic [15:0] ir;
    logic        halted, fault;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(9), .INSTR_W(16), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .pc_value    (pc_value),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .flag_z      (flag_z),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .pc_enOut    (pc_enOut),
        .pc_in_value (pc_in_value),
        .ir          (ir),
        .halted      (halted),
        .fault       (fault)
    );

    // Stimulus configuration
    logic [15:0] imem [512];
    logic [8:0]  pc_preset = 9'h000;
    int          ack_delay = 0;
    int          exec_k = 1;
    logic        done_glitch = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // program_counter stand-in
    always @(posedge clk) begin
        if (rst) pc_value <= pc_preset;
        else if (pc_load) pc_value <= pc_in_value;
        else if (pc_inc) pc_value <= pc_value + 9'd1;
    end

    // Instruction memory: ack after ack_delay wait cycles; garbage data otherwise
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || !mem_rd_req) begin
                mem_rd_ack = 1'b0; mem_rd_data = 16'hDEAD; wcnt = 0;
            end else if (wcnt >= ack_delay) begin
                mem_rd_ack = 1'b1; mem_rd_data = imem[pc_value]; wcnt = 0;
            end else begin
                mem_rd_ack = 1'b0; mem_rd_data = 16'hDEAD; wcnt++;
            end
        end
    end

    // Execute datapath: exec_done exec_k cycles after exec_start
    initial begin
        int ecnt;
        ecnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                exec_done = 1'b0; ecnt = 0;
            end else if (exec_start) begin
                exec_done = done_glitch; ecnt = exec_k;
            end else if (ecnt > 0) begin
                ecnt--; exec_done = (ecnt == 0);
            end else begin
                exec_done = 1'b0;
            end
        end
    end

    // Instruction-level reference model and per-cycle compare
    logic [8:0]  ref_pc, exp_tgt;
    logic [15:0] exp_ir;
    logic        exp_load, exp_alu, halt_armed, exp_halted, fault_armed, exp_fault;
    logic        ack_seen, in_instr;
    int          lat, nstart, exp_lat;
    logic [8:0]  stk [$];
    int          cnt_load = 0, cnt_inc = 0, cnt_start = 0, cnt_req = 0, cnt_en = 0;

    always @(negedge clk) begin
        if (rst) begin
            ref_pc = pc_preset; exp_ir = 16'h0; exp_tgt = 9'h0;
            exp_load = 0; exp_alu = 0; halt_armed = 0; exp_halted = 0;
            fault_armed = 0; exp_fault = 0; ack_seen = 0; in_instr = 0;
            lat = 0; nstart = 0;
            stk.delete();
        end else begin
            if (halt_armed) exp_halted = 1'b1;
            if (fault_armed) exp_fault = 1'b1;
            if (ack_seen) begin
                exp_ir   = imem[ref_pc];
                exp_tgt  = exp_ir[8:0];
                exp_load = 1'b0;
                exp_alu  = 1'b0;
                case (exp_ir[15:12])
                    4'hF: halt_armed = 1'b1;
                    4'hC: exp_load = 1'b1;
                    4'hD: exp_load = flag_z;
                    4'hE: exp_load = !flag_z;
`ifdef PC_SEQ_CALL_STACK_EN
                    4'hA: begin
                        if (stk.size() >= STACK_DEPTH) begin
                            halt_armed = 1'b1; fault_armed = 1'b1;
                        end else begin
                            stk.push_back(ref_pc + 9'd1); exp_load = 1'b1;
                        end
                    end
                    4'hB: begin
                        if (stk.size() == 0) begin
                            halt_armed = 1'b1; fault_armed = 1'b1;
                        end else begin
                            exp_tgt = stk.pop_back(); exp_load = 1'b1;
                        end
                    end
`endif
                    default: exp_alu = 1'b1;
                endcase
            end
            ack_seen = mem_rd_req && mem_rd_ack;

            if (pc_load) cnt_load++;
            if (pc_inc) cnt_inc++;
            if (exec_start) cnt_start++;
            if (mem_rd_req) cnt_req++;
            if (pc_enOut) cnt_en++;

            chk("ir", ir, exp_ir);
            chk("halted", halted, exp_halted);
            chk("fault", fault, exp_fault);
            chk("enout_vs_req", pc_enOut, mem_rd_req);
            chk("load_inc_exclusive", pc_load && pc_inc, 0);
            if (exp_halted) chk("halted_quiet", {mem_rd_req, pc_load, pc_inc, exec_start}, 0);

            if (in_instr) lat++;
            else if (mem_rd_req) begin
                in_instr = 1'b1; lat = 1; nstart = 0;
                chk("pc_at_fetch", pc_value, ref_pc);
            end
            if (exec_start) nstart++;

            if (pc_load || pc_inc) begin
                exp_lat = ack_delay + 1 + 1 + (exp_alu ? exec_k + 1 : 0) + 1;
                chk("update_is_load", pc_load, exp_load);
                if (exp_load) chk("pc_in_value", pc_in_value, exp_tgt);
                chk("latency", lat, exp_lat);
                chk("exec_start_count", nstart, exp_alu);
                ref_pc   = exp_load ? exp_tgt : ref_pc + 9'd1;
                in_instr = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
        step(1);
        run = 1'b0; rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Issue exactly one instruction: run high only for the IDLE->FETCH edge
    task automatic run_one();
        run = 1'b1;
        step(1);
        run = 1'b0;
        step(30);
    endtask

    task automatic wait_halted(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (halted) break;
            step(1);
        end
        chk(name, halted, 1);
    endtask

    int s_load, s_inc, s_start, s_req, s_en;
    task automatic snap();
        s_load = cnt_load; s_inc = cnt_inc; s_start = cnt_start;
        s_req = cnt_req; s_en = cnt_en;
    endtask

    initial begin
        do_reset();
        step(1);
        chk("reset_outputs", {mem_rd_req, exec_start, pc_load, pc_inc, pc_enOut, halted, fault}, 0);
        chk("reset_ir", ir, 16'h0);
        chk("reset_pc_in_value", pc_in_value, 9'h0);

        // ALU op, immediate ack, exec_done 2 cycles after start
        do_reset(); imem[0] = 16'h1000; exec_k = 2; snap();
        run_one();
        chk("alu_inc_pulses", cnt_inc - s_inc, 1);
        chk("alu_load_pulses", cnt_load - s_load, 0);
        chk("alu_exec_starts", cnt_start - s_start, 1);
        chk("alu_pc", pc_value, 9'h001);
        chk("alu_ir", ir, 16'h1000);
        chk("alu_idle_after", mem_rd_req, 0);
        exec_k = 1;

        // JMP 0x1CC
        do_reset(); imem[0] = 16'hC1CC; snap();
        run_one();
        chk("jmp_load_pulses", cnt_load - s_load, 1);
        chk("jmp_inc_pulses", cnt_inc - s_inc, 0);
        chk("jmp_no_exec", cnt_start - s_start, 0);
        chk("jmp_pc_in_value", pc_in_value, 9'h1CC);
        chk("jmp_pc", pc_value, 9'h1CC);

        // JZ 0x050, flag_z = 0 -> not taken
        do_reset(); imem[0] = 16'hD050; flag_z = 1'b0; snap();
        run_one();
        chk("jz0_inc_pulses", cnt_inc - s_inc, 1);
        chk("jz0_load_pulses", cnt_load - s_load, 0);
        chk("jz0_pc", pc_value, 9'h001);

        // JZ 0x050, flag_z = 1 -> taken
        do_reset(); imem[0] = 16'hD050; flag_z = 1'b1; snap();
        run_one();
        chk("jz1_load_pulses", cnt_load - s_load, 1);
        chk("jz1_pc_in_value", pc_in_value, 9'h050);
        chk("jz1_pc", pc_value, 9'h050);
        flag_z = 1'b0;

        // Ack delayed 3 cycles; exec_done glitch on the first EXEC cycle is ignored
        do_reset(); imem[0] = 16'h2000; ack_delay = 3; done_glitch = 1'b1; snap();
        run_one();
        chk("ackdly_req_cycles", cnt_req - s_req, 4);
        chk("ackdly_en_cycles", cnt_en - s_en, 4);
        chk("ackdly_ir", ir, 16'h2000);
        chk("ackdly_pc", pc_value, 9'h001);
        ack_delay = 0; done_glitch = 1'b0;

        // Short program under continuous run
        do_reset();
        imem[9'h000] = 16'h1000;
        imem[9'h001] = 16'hC005;
        imem[9'h005] = 16'hE00A;
        imem[9'h00A] = 16'h2345;
        imem[9'h00B] = 16'hD020;
        imem[9'h00C] = 16'hF000;
        run = 1'b1;
        wait_halted("prog_halted", 200);
        run = 1'b0;
        chk("prog_pc", pc_value, 9'h00C);
        chk("prog_ir", ir, 16'hF000);

        // HALT with run held high
        do_reset(); imem[0] = 16'hF000; snap();
        run = 1'b1;
        step(12);
        chk("halt_halted", halted, 1);
        chk("halt_req_cycles", cnt_req - s_req, 1);
        chk("halt_pc", pc_value, 9'h000);
        run = 1'b0;

        // Reset in the middle of EXEC
        do_reset(); imem[0] = 16'h1000; exec_k = 6;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (exec_start) break;
        end
        chk("rstexec_start_seen", exec_start, 1);
        run = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("rstexec_outputs", {mem_rd_req, exec_start, pc_load, pc_inc, pc_enOut, halted, fault}, 0);
        chk("rstexec_ir", ir, 16'h0);
        rst = 1'b0;
        step(10);
        chk("rstexec_stays_idle", {mem_rd_req, exec_start, pc_load, pc_inc}, 0);
        exec_k = 1;

`ifdef PC_SEQ_CALL_STACK_EN
        // CALL 0x100 at 0x010, RET back to 0x011
        pc_preset = 9'h010;
        do_reset();
        imem[9'h010] = 16'hA100;
        imem[9'h100] = 16'hB000;
        imem[9'h011] = 16'hF000;
        run = 1'b1;
        wait_halted("callret_halted", 100);
        run = 1'b0;
        chk("callret_pc", pc_value, 9'h011);
        chk("callret_fault", fault, 0);
        pc_preset = 9'h000;

        // Five nested CALLs overflow the 4-entry stack
        do_reset();
        for (int i = 0; i < 5; i++) imem[i] = 16'hA000 | 16'(i + 1);
        run = 1'b1;
        wait_halted("overflow_halted", 100);
        run = 1'b0;
        chk("overflow_fault", fault, 1);
        chk("overflow_pc", pc_value, 9'h004);

        // RET on an empty stack
        do_reset(); imem[0] = 16'hB000;
        run = 1'b1;
        wait_halted("underflow_halted", 50);
        run = 1'b0;
        chk("underflow_fault", fault, 1);
        chk("underflow_pc", pc_value, 9'h000);
`endif

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
